// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter
//   Shares the single port of data_ram_model between the core load/store unit (port 0) and the
//   MLP weight/activation loader (port 1). Round-robin arbitration with a combinational accept.
//   The winning command is registered onto the RAM port. Read data is routed back to the
//   issuing port RD_LAT+1 clocks after the accept edge.
//
//   Optional feature macro: RAM_ARB_LOCK_EN
//     Adds lock0_i/lock1_i and an owner FSM so that one port can hold the RAM across several
//     accepts, for example for a read-modify-write or a burst load.
//
//   Owner FSM (RAM_ARB_LOCK_EN only)
//     state | meaning
//     FREE  | plain round-robin between both ports
//     OWN0  | port 0 holds the RAM; port 1 stalls
//     OWN1  | port 1 holds the RAM; port 0 stalls
//
//   RD_LAT must be in the range 1..4.
module data_ram_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int WE_W   = DATA_W / 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [WE_W-1:0]   we0_i,
    output logic              gnt0_o,
    output logic              rvalid0_o,
    output logic [DATA_W-1:0] rdata0_o,

    input  logic              req1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata1_i,
    input  logic [WE_W-1:0]   we1_i,
    output logic              gnt1_o,
    output logic              rvalid1_o,
    output logic [DATA_W-1:0] rdata1_o,

`ifdef RAM_ARB_LOCK_EN
    input  logic              lock0_i,
    input  logic              lock1_i,
`endif

    output logic              ram_rst_o,
    output logic              ram_en_o,
    output logic [WE_W-1:0]   ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_din_o,
    input  logic [DATA_W-1:0] ram_dout_i
);

    // Round-robin pointer: 1 means port 1 was granted last, so port 0 wins the next tie.
    logic              last_q;

    // Per-port permission to be granted; both are always high without the lock feature.
    logic              allow0;
    logic              allow1;

    logic              gnt0;
    logic              gnt1;
    logic              any_gnt;

    // Command selected from the winning port.
    logic              sel_id;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_din;
    logic [WE_W-1:0]   sel_we;
    logic              sel_rd;

    // Registered RAM command.
    logic              ram_en_q;
    logic [WE_W-1:0]   ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_din_q;

    // Read tag travelling alongside the registered command.
    logic              cmd_rd_q;
    logic              cmd_id_q;

    // Tag delay line matching the RAM read latency.
    logic [RD_LAT-1:0] tag_vld_q;
    logic [RD_LAT-1:0] tag_id_q;
    logic              exit_vld;
    logic              exit_id;

    // Read return registers.
    logic              rvalid0_q;
    logic              rvalid1_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

`ifdef RAM_ARB_LOCK_EN
    typedef enum logic [1:0] {
        FREE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } owner_e;

    owner_e owner_q;
    logic   allow0_q;
    logic   allow1_q;

    // Owner FSM: a locked grant claims the RAM until the owner releases it or drops its request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q  <= FREE;
            allow0_q <= 1'b1;
            allow1_q <= 1'b1;
        end else begin
            case (owner_q)
                FREE: begin
                    if (gnt0 && lock0_i) begin
                        owner_q  <= OWN0;
                        allow1_q <= 1'b0;
                    end else if (gnt1 && lock1_i) begin
                        owner_q  <= OWN1;
                        allow0_q <= 1'b0;
                    end
                end
                OWN0: begin
                    if (!req0_i || (gnt0 && !lock0_i)) begin
                        owner_q  <= FREE;
                        allow1_q <= 1'b1;
                    end
                end
                OWN1: begin
                    if (!req1_i || (gnt1 && !lock1_i)) begin
                        owner_q  <= FREE;
                        allow0_q <= 1'b1;
                    end
                end
                default: begin
                    owner_q  <= FREE;
                    allow0_q <= 1'b1;
                    allow1_q <= 1'b1;
                end
            endcase
        end
    end

    assign allow0 = allow0_q;
    assign allow1 = allow1_q;
`else
    assign allow0 = 1'b1;
    assign allow1 = 1'b1;
`endif

    // Arbitration: a tie goes to the port not granted last; nothing is granted while in reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            if (req0_i && allow0 && req1_i && allow1) begin
                gnt0 = last_q;
                gnt1 = ~last_q;
            end else begin
                gnt0 = req0_i && allow0;
                gnt1 = req1_i && allow1;
            end
        end
    end

    assign any_gnt = gnt0 | gnt1;

    // Select the winning port's command for the RAM register stage.
    always_comb begin
        sel_id   = gnt1;
        sel_addr = addr0_i;
        sel_din  = wdata0_i;
        sel_we   = we0_i;
        if (gnt1) begin
            sel_addr = addr1_i;
            sel_din  = wdata1_i;
            sel_we   = we1_i;
        end
        sel_rd = any_gnt && (sel_we == '0);
    end

    // Command stage: register the accepted command; address and data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_en_q   <= 1'b0;
            ram_we_q   <= '0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            cmd_rd_q   <= 1'b0;
            cmd_id_q   <= 1'b0;
            last_q     <= 1'b1;
        end else if (any_gnt) begin
            ram_en_q   <= 1'b1;
            ram_we_q   <= sel_we;
            ram_addr_q <= sel_addr;
            ram_din_q  <= sel_din;
            cmd_rd_q   <= sel_rd;
            cmd_id_q   <= sel_id;
            last_q     <= sel_id;
        end else begin
            ram_en_q   <= 1'b0;
            ram_we_q   <= '0;
            cmd_rd_q   <= 1'b0;
        end
    end

    // Tag delay line: the tag leaves the last stage in the cycle the RAM presents its data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_q <= '0;
            tag_id_q  <= '0;
        end else begin
            tag_vld_q[0] <= cmd_rd_q;
            tag_id_q[0]  <= cmd_id_q;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_id_q[i]  <= tag_id_q[i-1];
            end
        end
    end

    assign exit_vld = tag_vld_q[RD_LAT-1];
    assign exit_id  = tag_id_q[RD_LAT-1];

    // Read return: capture RAM data for the issuing port as a one-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= exit_vld && !exit_id;
            rvalid1_q <= exit_vld && exit_id;
            if (exit_vld && !exit_id) begin
                rdata0_q <= ram_dout_i;
            end
            if (exit_vld && exit_id) begin
                rdata1_q <= ram_dout_i;
            end
        end
    end

    assign gnt0_o     = gnt0;
    assign gnt1_o     = gnt1;
    assign rvalid0_o  = rvalid0_q;
    assign rvalid1_o  = rvalid1_q;
    assign rdata0_o   = rdata0_q;
    assign rdata1_o   = rdata1_q;

    assign ram_rst_o  = ~rst_n;
    assign ram_en_o   = ram_en_q;
    assign ram_we_o   = ram_we_q;
    assign ram_addr_o = ram_addr_q;
    assign ram_din_o  = ram_din_q;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Testbench for data_ram_arbiter: directed scenarios followed by randomized traffic, all checked
// every cycle against a transaction-level model (grant rule, shadow memory, queue of expected
// read returns). Lock scenarios run only when RAM_ARB_LOCK_EN is defined.
module tb_data_ram_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int WW = DW / 8;
    localparam int RL = 1;
`ifdef RAM_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bit            p_req  [2];
    logic [AW-1:0] p_addr [2];
    logic [DW-1:0] p_wd   [2];
    logic [WW-1:0] p_we   [2];
    bit            p_lock [2];

    logic          req0, req1, lock0, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic [WW-1:0] we0, we1;
    assign req0 = p_req[0];   assign req1 = p_req[1];
    assign addr0 = p_addr[0]; assign addr1 = p_addr[1];
    assign wdata0 = p_wd[0];  assign wdata1 = p_wd[1];
    assign we0 = p_we[0];     assign we1 = p_we[1];
    assign lock0 = p_lock[0]; assign lock1 = p_lock[1];

    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          ram_rst, ram_en;
    logic [WW-1:0] ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_dout;

    data_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WE_W(WW), .RD_LAT(RL)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_i(req0), .addr0_i(addr0), .wdata0_i(wdata0), .we0_i(we0),
        .gnt0_o(gnt0), .rvalid0_o(rvalid0), .rdata0_o(rdata0),
        .req1_i(req1), .addr1_i(addr1), .wdata1_i(wdata1), .we1_i(we1),
        .gnt1_o(gnt1), .rvalid1_o(rvalid1), .rdata1_o(rdata1),
`ifdef RAM_ARB_LOCK_EN
        .lock0_i(lock0), .lock1_i(lock1),
`endif
        .ram_rst_o(ram_rst), .ram_en_o(ram_en), .ram_we_o(ram_we),
        .ram_addr_o(ram_addr), .ram_din_o(ram_din), .ram_dout_i(ram_dout)
    );

    function automatic logic [DW-1:0] init_word(int i);
        return (i == 32'h20) ? '0 : (32'hCAFE0000 | 32'(i));
    endfunction

    // RAM model: registered read with RL clocks latency, byte-lane writes, reloaded during reset.
    logic [DW-1:0] ram_mem [256];
    logic [DW-1:0] rd_pipe [RL];
    assign ram_dout = rd_pipe[RL-1];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= init_word(i);
        end else if (ram_en) begin
            if (ram_we != '0) begin
                for (int b = 0; b < WW; b++)
                    if (ram_we[b]) ram_mem[ram_addr[7:0]][8*b +: 8] <= ram_din[8*b +: 8];
            end else begin
                rd_pipe[0] <= ram_mem[ram_addr[7:0]];
            end
        end
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    // Transaction-level reference model.
    typedef struct { int due; bit id; logic [DW-1:0] data; } rd_t;
    rd_t           rq[$];
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            last_m = 1;
    int            own_m = -1;
    logic          exp_en;
    logic [WW-1:0] exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_din;
    logic [DW-1:0] sh_mem [256];
    bit            pw_v;
    logic [7:0]    pw_addr;
    logic [DW-1:0] pw_data;
    logic [WW-1:0] pw_we;
    bit            obs_g0, obs_g1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Grant rule: owner excludes the other port; tie goes to the port not served last.
    function automatic void model_grant(output bit g0, output bit g1);
        bit a0, a1;
        g0 = 0; g1 = 0;
        if (rst_n !== 1'b1) return;
        a0 = (own_m != 1);
        a1 = (own_m != 0);
        if (req0 && a0 && req1 && a1) begin
            if (last_m == 1) g0 = 1; else g1 = 1;
        end else begin
            g0 = req0 && a0;
            g1 = req1 && a1;
        end
    endfunction

    task automatic model_edge(input bit g0, input bit g1);
        int p;
        logic [7:0] a;
        if (rst_n !== 1'b1) begin
            last_m = 1; own_m = -1;
            exp_en = 0; exp_we = '0; exp_addr = '0; exp_din = '0;
            rq.delete(); pw_v = 0;
            for (int i = 0; i < 256; i++) sh_mem[i] = init_word(i);
            return;
        end
        if (pw_v) begin
            for (int b = 0; b < WW; b++)
                if (pw_we[b]) sh_mem[pw_addr][8*b +: 8] = pw_data[8*b +: 8];
            pw_v = 0;
        end
        if (g0 || g1) begin
            p = g1 ? 1 : 0;
            a = p_addr[p][7:0];
            last_m = p;
            exp_en = 1; exp_we = p_we[p]; exp_addr = p_addr[p]; exp_din = p_wd[p];
            if (p_we[p] == '0) rq.push_back('{due: cyc + RL + 1, id: g1, data: sh_mem[a]});
            else begin pw_v = 1; pw_addr = a; pw_data = p_wd[p]; pw_we = p_we[p]; end
        end else begin
            exp_en = 0; exp_we = '0;
        end
        if (own_m == -1) begin
            if (g0 && lock0) own_m = 0;
            else if (g1 && lock1) own_m = 1;
        end else if (own_m == 0) begin
            if (!req0 || (g0 && !lock0)) own_m = -1;
        end else begin
            if (!req1 || (g1 && !lock1)) own_m = -1;
        end
    endtask

    // One clock: check grants mid-cycle, advance the model, check registered outputs after the edge.
    task automatic step();
        bit m0, m1, e0, e1;
        logic [DW-1:0] ed;
        #1;
        model_grant(m0, m1);
        chk("gnt0", gnt0, m0);
        chk("gnt1", gnt1, m1);
        chk("ram_rst", ram_rst, !rst_n);
        obs_g0 = gnt0; obs_g1 = gnt1;
        cyc++;
        model_edge(m0, m1);
        @(posedge clk);
        #1;
        chk("ram_en", ram_en, exp_en);
        chk("ram_we", ram_we, exp_we);
        chk("ram_addr", ram_addr, exp_addr);
        chk("ram_din", ram_din, exp_din);
        e0 = 0; e1 = 0; ed = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            if (rq[0].id) e1 = 1; else e0 = 1;
            ed = rq[0].data;
            void'(rq.pop_front());
        end
        chk("rvalid0", rvalid0, e0);
        chk("rvalid1", rvalid1, e1);
        if (e0) chk("rdata0", rdata0, ed);
        if (e1) chk("rdata1", rdata1, ed);
        @(negedge clk);
    endtask

    // Random command per port: a waiting request usually holds, sometimes cancels.
    task automatic gen(input int p);
        bit g;
        g = (p == 0) ? obs_g0 : obs_g1;
        if (p_req[p] && !g && $urandom_range(0, 4) != 0) return;
        p_req[p]  = ($urandom_range(0, 9) < 6);
        p_addr[p] = ($urandom_range(0, 7) == 0) ? 32'h20 : AW'($urandom_range(0, 15));
        p_we[p]   = ($urandom_range(0, 1) == 0) ? '0 : WW'($urandom_range(1, 15));
        p_wd[p]   = $urandom;
        p_lock[p] = LOCK_EN && ($urandom_range(0, 2) == 0);
    endtask

    task automatic set_cmd(input int p, input bit r, input logic [AW-1:0] a,
                           input logic [WW-1:0] w, input logic [DW-1:0] d);
        p_req[p] = r; p_addr[p] = a; p_we[p] = w; p_wd[p] = d; p_lock[p] = 0;
    endtask

    initial begin
        int order[4];
        for (int p = 0; p < 2; p++) set_cmd(p, 0, '0, '0, '0);

        // Reset held two cycles with both ports requesting.
        rst_n = 0;
        set_cmd(0, 1, 32'h3, '0, '0);
        set_cmd(1, 1, 32'h7, '0, '0);
        @(negedge clk);
        step(); step();
        chk("rst_gnt0", obs_g0, 1'b0);
        chk("rst_gnt1", obs_g1, 1'b0);
        chk("rst_ram_en", ram_en, 1'b0);
        chk("rst_rvalid0", rvalid0, 1'b0);
        chk("rst_rvalid1", rvalid1, 1'b0);
        chk("rst_rdata0", rdata0, 32'h0);
        chk("rst_ram_addr", ram_addr, 32'h0);

        // Contention for four cycles: first winner is port 0, then alternating.
        rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            order[k] = obs_g1 ? 1 : (obs_g0 ? 0 : -1);
        end
        for (int k = 0; k < 4; k++) chk("contention_order", 64'(order[k]), 64'(k % 2));
        set_cmd(0, 0, '0, '0, '0); set_cmd(1, 0, '0, '0, '0);
        repeat (3) step();

        // Single read from port 0.
        set_cmd(0, 1, 32'h10, '0, '0);
        step();
        chk("single_gnt0", obs_g0, 1'b1);
        chk("single_ram_en", ram_en, 1'b1);
        chk("single_ram_addr", ram_addr, 32'h10);
        set_cmd(0, 0, '0, '0, '0);
        step();
        chk("single_rvalid0_early", rvalid0, 1'b0);
        step();
        chk("single_rvalid0", rvalid0, 1'b1);
        chk("single_rdata0", rdata0, 32'hCAFE0010);
        chk("single_rvalid1", rvalid1, 1'b0);

        // Partial write from port 1, then read back from port 0.
        set_cmd(1, 1, 32'h20, 4'b1110, 32'h12345678);
        step();
        chk("pw_ram_we", ram_we, 4'b1110);
        set_cmd(1, 0, '0, '0, '0);
        step();
        chk("pw_ram_we_clear", ram_we, 4'b0000);
        set_cmd(0, 1, 32'h20, '0, '0);
        step();
        set_cmd(0, 0, '0, '0, '0);
        step(); step();
        chk("pw_readback", rdata0, 32'h12345600);

        // Reset one cycle after a port-1 read is accepted.
        set_cmd(1, 1, 32'h5, '0, '0);
        step();
        chk("rmid_gnt1", obs_g1, 1'b1);
        set_cmd(1, 0, '0, '0, '0);
        rst_n = 0;
        step();
        chk("rmid_ram_en", ram_en, 1'b0);
        step();
        rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rmid_no_rvalid1", rvalid1, 1'b0);
        end

`ifdef RAM_ARB_LOCK_EN
        // Port 0 locks for three reads while port 1 waits.
        set_cmd(0, 1, 32'h1, '0, '0); p_lock[0] = 1;
        step();
        chk("lock_first_gnt0", obs_g0, 1'b1);
        set_cmd(1, 1, 32'h2, '0, '0);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("lock_gnt1_stall", obs_g1, 1'b0);
        end
        p_lock[0] = 0;
        step();
        chk("lock_release_gnt0", obs_g0, 1'b1);
        step();
        chk("lock_after_gnt1", obs_g1, 1'b1);
        set_cmd(0, 0, '0, '0, '0); set_cmd(1, 0, '0, '0, '0);
        repeat (3) step();
`endif

        // Randomized traffic, with an occasional reset.
        for (int n = 0; n < 3000; n++) begin
            gen(0); gen(1);
            if (n % 700 == 350) rst_n = 0;
            else rst_n = 1;
            step();
        end
        rst_n = 1;
        set_cmd(0, 0, '0, '0, '0); set_cmd(1, 0, '0, '0, '0);
        repeat (RL + 3) step();
        chk("queue_drained", 64'(rq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
